// File: rtl/cosim_chg_collector.sv
`default_nettype none
// =============================================================================
// cosim_chg_collector : packs retirement events into double-buffered cosim
//                       change records (insn list, op list, trap info).
//                       Optional trap capture: `COSIM_TRAP_CAPTURE_EN.
// Revision 1.0
// =============================================================================
module cosim_chg_collector #(
    parameter int MAX_INSN = 4,
    parameter int MAX_OP   = 16,
    localparam int IW = $clog2(MAX_INSN + 1),
    localparam int OW = $clog2(MAX_OP + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    in_ready,
    input  logic                    ins_valid,
    input  logic [1:0]              ins_prv,
    input  logic [63:0]             ins_pc,
    input  logic [31:0]             ins_ir,
    input  logic                    op_valid,
    input  logic [4:0]              op_access,
    input  logic [63:0]             op_addr,
    input  logic [63:0]             op_data,
    input  logic                    trp_valid,
    input  logic [3:0]              trp_cause,
    input  logic [1:0]              trp_prv,
    input  logic [63:0]             trp_badaddr,
    input  logic                    step_end,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IW-1:0]           out_inum,
    output logic [OW-1:0]           out_opnum,
    output logic [2*MAX_INSN-1:0]   out_insn_prv,
    output logic [64*MAX_INSN-1:0]  out_insn_pc,
    output logic [32*MAX_INSN-1:0]  out_insn_ir,
    output logic [5*MAX_OP-1:0]     out_op_access,
    output logic [64*MAX_OP-1:0]    out_op_addr,
    output logic [64*MAX_OP-1:0]    out_op_data,
    output logic [2*MAX_OP-1:0]     out_op_inum,
    output logic                    out_trp,
    output logic [3:0]              out_trp_cause,
    output logic [1:0]              out_trp_prv,
    output logic [63:0]             out_trp_badaddr,
    output logic                    out_ovf
);

    typedef struct packed {
        logic [IW-1:0]          icnt;
        logic [OW-1:0]          ocnt;
        logic                   ovf;
        logic [2*MAX_INSN-1:0]  iprv;
        logic [64*MAX_INSN-1:0] ipc;
        logic [32*MAX_INSN-1:0] iir;
        logic [5*MAX_OP-1:0]    oacc;
        logic [64*MAX_OP-1:0]   oaddr;
        logic [64*MAX_OP-1:0]   odata;
        logic [2*MAX_OP-1:0]    oinum;
`ifdef COSIM_TRAP_CAPTURE_EN
        logic                   trp;
        logic [3:0]             tcause;
        logic [1:0]             tprv;
        logic [63:0]            tbad;
`endif
    } bank_t;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_WAIT    = 1'b1
    } state_t;

    state_t     state_q, state_d;
    bank_t      fill_q, fill_d, out_q, out_d;
    logic       out_valid_q, out_valid_d;
    bank_t      w_fill;
    logic       w_trp_acc, w_has_trp, w_close, w_empty, w_pop;
    logic [1:0] w_inum;

`ifdef COSIM_TRAP_CAPTURE_EN
    assign w_trp_acc = in_ready && trp_valid;
    assign w_has_trp = w_fill.trp;
`else
    logic w_trp_unused;
    assign w_trp_unused = ^{trp_valid, trp_cause, trp_prv, trp_badaddr};
    assign w_trp_acc    = 1'b0;
    assign w_has_trp    = 1'b0;
`endif

    assign in_ready = (state_q == S_COLLECT);
    assign w_close  = in_ready && (step_end || w_trp_acc);
    assign w_empty  = (w_fill.icnt == '0) && (w_fill.ocnt == '0) && !w_has_trp;
    assign w_pop    = out_valid_q && out_ready;

    // FILL bank with this cycle's accepted events merged in
    always_comb begin
        w_fill = fill_q;
        w_inum = 2'd0;
        if (in_ready && ins_valid) begin
            if (fill_q.icnt == IW'(MAX_INSN)) begin
                w_fill.ovf = 1'b1;
            end else begin
                w_fill.iprv[int'(fill_q.icnt)*2  +: 2]  = ins_prv;
                w_fill.ipc [int'(fill_q.icnt)*64 +: 64] = ins_pc;
                w_fill.iir [int'(fill_q.icnt)*32 +: 32] = ins_ir;
                w_fill.icnt = fill_q.icnt + IW'(1);
            end
        end
        if (w_fill.icnt != '0) begin
            w_inum = 2'(w_fill.icnt - IW'(1));
        end
        if (in_ready && op_valid) begin
            if (fill_q.ocnt == OW'(MAX_OP)) begin
                w_fill.ovf = 1'b1;
            end else begin
                w_fill.oacc [int'(fill_q.ocnt)*5  +: 5]  = op_access;
                w_fill.oaddr[int'(fill_q.ocnt)*64 +: 64] = op_addr;
                w_fill.odata[int'(fill_q.ocnt)*64 +: 64] = op_data;
                w_fill.oinum[int'(fill_q.ocnt)*2  +: 2]  = w_inum;
                w_fill.ocnt = fill_q.ocnt + OW'(1);
            end
        end
`ifdef COSIM_TRAP_CAPTURE_EN
        if (w_trp_acc) begin
            w_fill.trp    = 1'b1;
            w_fill.tcause = trp_cause;
            w_fill.tprv   = trp_prv;
            w_fill.tbad   = trp_badaddr;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (w_pop) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_COLLECT: begin
                fill_d = w_fill;
                if (w_close) begin
                    if (w_empty) begin
                        fill_d = '0;
                    end else if (!out_valid_q || out_ready) begin
                        out_d       = w_fill;
                        out_valid_d = 1'b1;
                        fill_d      = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_pop) begin
                    out_d       = fill_q;
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                    state_d     = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            fill_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_inum      = out_q.icnt;
    assign out_opnum     = out_q.ocnt;
    assign out_ovf       = out_q.ovf;
    assign out_insn_prv  = out_q.iprv;
    assign out_insn_pc   = out_q.ipc;
    assign out_insn_ir   = out_q.iir;
    assign out_op_access = out_q.oacc;
    assign out_op_addr   = out_q.oaddr;
    assign out_op_data   = out_q.odata;
    assign out_op_inum   = out_q.oinum;
`ifdef COSIM_TRAP_CAPTURE_EN
    assign out_trp         = out_q.trp;
    assign out_trp_cause   = out_q.tcause;
    assign out_trp_prv     = out_q.tprv;
    assign out_trp_badaddr = out_q.tbad;
`else
    assign out_trp         = 1'b0;
    assign out_trp_cause   = 4'd0;
    assign out_trp_prv     = 2'd0;
    assign out_trp_badaddr = 64'd0;
`endif

endmodule
`default_nettype wire
